fifo_fwft_sync: RTL and testbench
=================================

// Module: fifo_fwft_sync
// PURPOSE
// - Parametrised synchronous first-word-fall-through FIFO. Storage is an inferred flop array, not an SRAM macro.
// - Adds fill level, programmable almost-full/almost-empty flags and an optional synchronous flush.
// - Sits between accelerator stages: producer valid/ready on the input, consumer valid/ready on the output.
// PARAMETERS
// - WIDTH          8  data word width in bits (>=1)
// - LOG2_OF_DEPTH  4  DEPTH = 2**LOG2_OF_DEPTH entries (>=1)
// - AF_THRESH     12  almost_full asserts when level >= AF_THRESH (1..DEPTH)
// - AE_THRESH      2  almost_empty asserts when level <= AE_THRESH (0..DEPTH-1)
// PORTS
// - clk           in   1                  clock, rising edge
// - rst_in        in   1                  synchronous reset, active-high
// - din           in   WIDTH              write data
// - input_valid   in   1                  producer has data
// - input_ready   out  1                  FIFO can accept (not full)
// - qout          out  WIDTH              head-of-FIFO data (FWFT)
// - output_valid  out  1                  qout holds a valid entry (not empty)
// - output_ready  in   1                  consumer takes qout this cycle
// - level         out  LOG2_OF_DEPTH+1    current occupancy, 0..DEPTH
// - almost_full   out  1                  level >= AF_THRESH
// - almost_empty  out  1                  level <= AE_THRESH
// - flush_in      in   1                  only if FIFO_FLUSH_EN is defined
// BEHAVIOUR
// - Pointers: wr_ptr and rd_ptr, each LOG2_OF_DEPTH+1 bits, wrap modulo 2**(LOG2_OF_DEPTH+1).
//   - The MSB disambiguates full from empty. The low bits index memory.
// - Outputs are derived only from registered pointers. There is no combinational path from input_valid/output_ready to any output.
//   - level = wr_ptr - rd_ptr (modular subtraction)
//   - full = (level == DEPTH), empty = (level == 0)
//   - input_ready = !full, output_valid = !empty
// - Write: on input_valid && input_ready, mem[wr_ptr] <= din and wr_ptr increments.
//   - When full, input_valid is ignored (no write, no pointer change).
// - Read: qout = mem[rd_ptr] (asynchronous read from flops). On output_valid && output_ready, rd_ptr increments.
//   - When empty, qout is don't-care and output_ready is ignored.
// - Latency: a word written at edge N is on qout with output_valid=1 after edge N. Write-to-read turnaround is 1 cycle. No bypass when empty.
// - Simultaneous write+read when neither full nor empty: both occur, level unchanged.
//   - When full, only the read occurs (input_ready=0). When empty, only the write occurs.
// - Throughput: 1 word/cycle sustained in both directions.
// - Reset (rst_in=1 at an edge): wr_ptr=rd_ptr=0.
//   - Next cycle: input_ready=1, output_valid=0, level=0, almost_empty=1, almost_full=0.
//   - Memory contents are not reset.
//   - Reset mid-operation discards all entries. Any handshake in the reset cycle is dropped.
// - Flags are combinational from level and settle the cycle after the pointer update.
// CONFIGURATION
// - Macro FIFO_FLUSH_EN.
// - Defined: flush_in port exists. flush_in=1 at an edge sets wr_ptr <= rd_ptr, emptying the FIFO next cycle.
//   - While flush_in=1, input_ready and output_valid are forced 0, so no transfer completes that cycle.
//   - rst_in has priority over flush_in.
// - Undefined: no flush_in port and no flush logic. Behaviour is otherwise identical.
// STRUCTURE
// - Package fifo_pkg:
//   - ptr_t typedef (LOG2_OF_DEPTH+1 bits)
//   - function level_of(wr, rd)
//   - localparam DEPTH derivation
// - Sub-module fifo_regfile_1w1r: WIDTH x DEPTH flop array with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). No reset.
// - Top level holds pointers, flags and the handshake logic.
// TESTING (WIDTH=8, LOG2_OF_DEPTH=2, AF_THRESH=3, AE_THRESH=1)
// - Reset: assert rst_in 2 cycles -> input_ready=1, output_valid=0, level=0, almost_empty=1, almost_full=0.
// - Fill: write 0x11,0x22,0x33,0x44 back-to-back with output_ready=0
//   -> level 1,2,3,4; almost_full from level=3; input_ready=0 at level=4; 5th write 0x55 is not accepted.
// - Drain: output_ready=1 from full -> qout 0x11,0x22,0x33,0x44 on consecutive cycles, then output_valid=0.
// - Concurrency: hold level=2 with input_valid=output_ready=1 for 20 cycles of an incrementing pattern
//   -> level stays 2, output is in order, pointers wrap at least twice.
//   - Also exercise the full boundary: a write and read in the same cycle accept only the read.
// - Mid-operation reset: level=3, rst_in=1 in the same cycle as a write -> next cycle level=0, and the write is dropped.
// - FIFO_FLUSH_EN: level=4, flush_in=1 with input_valid=1 -> input_ready=0 that cycle, level=0 next cycle.
//   - A subsequent write of 0xA5 appears on qout one cycle later.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and helpers for the synchronous FWFT FIFO.
//               - ptr_t      : widest supported pointer type. Each FIFO
//                              instance keeps LOG2_OF_DEPTH+1 bit pointers
//                              and narrows helper results back to that width.
//               - depth_of() : DEPTH derivation, 2**LOG2_OF_DEPTH.
//               - level_of() : occupancy from write/read pointers.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int unsigned c_PTR_W_MAX = 32;

    typedef logic [c_PTR_W_MAX-1:0] ptr_t;

    function automatic int unsigned depth_of(input int unsigned log2_of_depth);
        return 32'd1 << log2_of_depth;
    endfunction

    // Plain subtraction. The caller truncates the result to its own pointer
    // width, which turns it into the modulo-2**(LOG2_OF_DEPTH+1) difference.
    function automatic ptr_t level_of(input ptr_t wr, input ptr_t rd);
        return wr - rd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_regfile_1w1r.sv
`default_nettype none
// ============================================================================
// Module      : fifo_regfile_1w1r
// Description : WIDTH x 2**ADDR_W flop array, one synchronous write port and
//               one asynchronous read port. Contents are not reset.
// Ports       : clk              - clock, rising edge
//               we/waddr/wdata   - write enable, address, data
//               raddr/rdata      - read address, combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_regfile_1w1r
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int unsigned c_DEPTH = depth_of(ADDR_W);

    logic [WIDTH-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_fwft_sync.sv
`default_nettype none
// ============================================================================
// Module      : fifo_fwft_sync
// Description : Synchronous first-word-fall-through FIFO with fill level and
//               almost-full / almost-empty flags. Storage is a flop array.
//               Optional synchronous flush when macro FIFO_FLUSH_EN is
//               defined (adds port flush_in).
// Ports       : clk, rst_in                  - clock, sync active-high reset
//               flush_in                     - flush (FIFO_FLUSH_EN only)
//               din/input_valid/input_ready  - producer handshake
//               qout/output_valid/output_ready - consumer handshake (FWFT)
//               level                        - occupancy 0..DEPTH
//               almost_full / almost_empty   - level >= AF / level <= AE
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_fwft_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int LOG2_OF_DEPTH = 4,
    parameter int AF_THRESH     = 12,
    parameter int AE_THRESH     = 2
) (
    input  logic                     clk,
    input  logic                     rst_in,
`ifdef FIFO_FLUSH_EN
    input  logic                     flush_in,
`endif
    input  logic [WIDTH-1:0]         din,
    input  logic                     input_valid,
    output logic                     input_ready,
    output logic [WIDTH-1:0]         qout,
    output logic                     output_valid,
    input  logic                     output_ready,
    output logic [LOG2_OF_DEPTH:0]   level,
    output logic                     almost_full,
    output logic                     almost_empty
);

    localparam int                 c_PTR_W      = LOG2_OF_DEPTH + 1;
    localparam int unsigned        c_DEPTH      = depth_of(LOG2_OF_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LEVEL_FULL = c_PTR_W'(c_DEPTH);
    localparam logic [c_PTR_W-1:0] c_AF_LEVEL   = c_PTR_W'(AF_THRESH);
    localparam logic [c_PTR_W-1:0] c_AE_LEVEL   = c_PTR_W'(AE_THRESH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);

    // Pointers carry one extra MSB so that equal low bits can be told apart
    // as either empty (MSBs equal) or full (MSBs differ).
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] w_level;
    logic               w_full;
    logic               w_empty;
    logic               w_flush;
    logic               w_wr_en;
    logic               w_rd_en;

`ifdef FIFO_FLUSH_EN
    assign w_flush = flush_in;
`else
    assign w_flush = 1'b0;
`endif

    assign w_level = c_PTR_W'(level_of(ptr_t'(r_wr_ptr), ptr_t'(r_rd_ptr)));
    assign w_full  = (w_level == c_LEVEL_FULL);
    assign w_empty = (w_level == '0);

    // Handshake outputs depend only on registered pointers (and flush, which
    // deliberately blocks both sides during the cycle it is asserted).
    assign input_ready  = !w_full  && !w_flush;
    assign output_valid = !w_empty && !w_flush;

    assign w_wr_en = input_valid  && input_ready;
    assign w_rd_en = output_valid && output_ready;

    assign level        = w_level;
    assign almost_full  = (w_level >= c_AF_LEVEL);
    assign almost_empty = (w_level <= c_AE_LEVEL);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_flush) begin
            // Discard contents by catching the write pointer up to the reader.
            r_wr_ptr <= r_rd_ptr;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    fifo_regfile_1w1r #(
        .WIDTH  (WIDTH),
        .ADDR_W (LOG2_OF_DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (w_wr_en && !rst_in),
        .waddr (r_wr_ptr[LOG2_OF_DEPTH-1:0]),
        .wdata (din),
        .raddr (r_rd_ptr[LOG2_OF_DEPTH-1:0]),
        .rdata (qout)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_fwft_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_fwft_sync
// Description : Self-checking bench for fifo_fwft_sync (WIDTH=8, DEPTH=4,
//               AF_THRESH=3, AE_THRESH=1). Table-driven reset/fill/drain,
//               hand-written corner sequences, then random traffic against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_fwft_sync;

    localparam int c_W     = 8;
    localparam int c_L2    = 2;
    localparam int c_DEPTH = 4;
    localparam int c_AF    = 3;
    localparam int c_AE    = 1;

    logic             clk = 1'b0;
    logic             rst_in = 1'b1;
    logic             flush_drv = 1'b0;
    logic [c_W-1:0]   din = '0;
    logic             input_valid = 1'b0;
    logic             input_ready;
    logic [c_W-1:0]   qout;
    logic             output_valid;
    logic             output_ready = 1'b0;
    logic [c_L2:0]    level;
    logic             almost_full;
    logic             almost_empty;

    int n_tests = 0;
    int n_fail  = 0;

    logic [c_W-1:0] model_q[$];

    always #5 clk = ~clk;

    fifo_fwft_sync #(
        .WIDTH         (c_W),
        .LOG2_OF_DEPTH (c_L2),
        .AF_THRESH     (c_AF),
        .AE_THRESH     (c_AE)
    ) dut (
        .clk          (clk),
        .rst_in       (rst_in),
`ifdef FIFO_FLUSH_EN
        .flush_in     (flush_drv),
`endif
        .din          (din),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .qout         (qout),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one clock's worth of inputs, advance the reference model across
    // the edge, then return inputs to idle at edge+1 where outputs are sampled.
    task automatic cycle(input logic r, input logic iv, input logic [c_W-1:0] d,
                         input logic ordy, input logic fl);
        logic acc_in;
        logic acc_out;
        rst_in       = r;
        input_valid  = iv;
        din          = d;
        output_ready = ordy;
        flush_drv    = fl;
        acc_in  = !fl && (model_q.size() < c_DEPTH) && iv;
        acc_out = !fl && (model_q.size() > 0) && ordy;
        @(posedge clk);
        if (r || fl) begin
            model_q.delete();
        end else begin
            if (acc_out) void'(model_q.pop_front());
            if (acc_in)  model_q.push_back(d);
        end
        #1;
        rst_in       = 1'b0;
        input_valid  = 1'b0;
        output_ready = 1'b0;
        flush_drv    = 1'b0;
        din          = '0;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = model_q.size();
        check({tag, " level"},        32'(level),        32'(n));
        check({tag, " input_ready"},  32'(input_ready),  32'(n < c_DEPTH));
        check({tag, " output_valid"}, 32'(output_valid), 32'(n > 0));
        check({tag, " almost_full"},  32'(almost_full),  32'(n >= c_AF));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= c_AE));
        if (n > 0) check({tag, " qout"}, 32'(qout), 32'(model_q[0]));
    endtask

    typedef struct {
        int rst; int iv; int din; int ordy;
        int lvl; int ir; int ov; int af; int ae; int chk_q; int q;
    } vec_t;

    vec_t vecs[11];

    initial begin
        //          rst iv din    ordy lvl ir ov af ae chkq q
        vecs[0]  = '{1, 0, 'h00, 0,   0,  1, 0, 0, 1, 0, 'h00};
        vecs[1]  = '{1, 0, 'h00, 0,   0,  1, 0, 0, 1, 0, 'h00};
        vecs[2]  = '{0, 1, 'h11, 0,   1,  1, 1, 0, 1, 1, 'h11};
        vecs[3]  = '{0, 1, 'h22, 0,   2,  1, 1, 0, 0, 1, 'h11};
        vecs[4]  = '{0, 1, 'h33, 0,   3,  1, 1, 1, 0, 1, 'h11};
        vecs[5]  = '{0, 1, 'h44, 0,   4,  0, 1, 1, 0, 1, 'h11};
        vecs[6]  = '{0, 1, 'h55, 0,   4,  0, 1, 1, 0, 1, 'h11};
        vecs[7]  = '{0, 0, 'h00, 1,   3,  1, 1, 1, 0, 1, 'h22};
        vecs[8]  = '{0, 0, 'h00, 1,   2,  1, 1, 0, 0, 1, 'h33};
        vecs[9]  = '{0, 0, 'h00, 1,   1,  1, 1, 0, 1, 1, 'h44};
        vecs[10] = '{0, 0, 'h00, 1,   0,  1, 0, 0, 1, 0, 'h00};

        // Reset, fill to full (5th write refused), drain in order.
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].rst != 0, vecs[i].iv != 0, 8'(vecs[i].din), vecs[i].ordy != 0, 1'b0);
            check($sformatf("vec%0d level", i),        32'(level),        32'(vecs[i].lvl));
            check($sformatf("vec%0d input_ready", i),  32'(input_ready),  32'(vecs[i].ir));
            check($sformatf("vec%0d output_valid", i), 32'(output_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d almost_full", i),  32'(almost_full),  32'(vecs[i].af));
            check($sformatf("vec%0d almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
            if (vecs[i].chk_q != 0)
                check($sformatf("vec%0d qout", i), 32'(qout), 32'(vecs[i].q));
        end

        // Steady state at level 2 with simultaneous read and write.
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        check("conc prefill level", 32'(level), 32'd2);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b1, 8'(k + 2), 1'b1, 1'b0);
            check($sformatf("conc%0d level", k), 32'(level), 32'd2);
            check($sformatf("conc%0d qout", k),  32'(qout),  32'(k + 1));
        end

        // Full boundary: write+read while full only performs the read.
        cycle(1'b0, 1'b1, 8'h60, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h61, 1'b0, 1'b0);
        check("full level", 32'(level), 32'd4);
        check("full input_ready", 32'(input_ready), 32'd0);
        cycle(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        check("full wr+rd level", 32'(level), 32'd3);
        check_model("full wr+rd");
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check_model($sformatf("full drain%0d", k));
        end
        check("full drain empty", 32'(output_valid), 32'd0);

        // Reset mid-operation at level 3 drops the concurrent write.
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 8'(8'h90 + k), 1'b0, 1'b0);
        check("midrst pre level", 32'(level), 32'd3);
        cycle(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        check("midrst level", 32'(level), 32'd0);
        check("midrst output_valid", 32'(output_valid), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("midrst after level", 32'(level), 32'd0);

`ifdef FIFO_FLUSH_EN
        // Flush from full: both handshakes blocked during the flush cycle.
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
        check("flush pre level", 32'(level), 32'd4);
        flush_drv   = 1'b1;
        input_valid = 1'b1;
        din         = 8'hBB;
        #1;
        check("flush input_ready", 32'(input_ready), 32'd0);
        check("flush output_valid", 32'(output_valid), 32'd0);
        @(posedge clk);
        model_q.delete();
        #1;
        flush_drv   = 1'b0;
        input_valid = 1'b0;
        din         = '0;
        check("flush level", 32'(level), 32'd0);
        cycle(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        check("flush A5 qout", 32'(qout), 32'h0A5);
        check("flush A5 output_valid", 32'(output_valid), 32'd1);
        check("flush A5 level", 32'(level), 32'd1);
`endif

        // Random traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            logic r;
            logic fl;
            r = ($urandom_range(0, 59) == 0);
`ifdef FIFO_FLUSH_EN
            fl = ($urandom_range(0, 39) == 0);
`else
            fl = 1'b0;
`endif
            cycle(r, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), fl);
            check_model($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
